spec_peak_find: RTL and testbench

SPEC_PEAK_FIND -- requirements
Module: spec_peak_find

---
 rtl/spec_pkg.sv | 20 ++
 rtl/spec_peak_find_if.sv | 13 +
 rtl/peak_rank2.sv | 70 +++++++
 rtl/spec_peak_find.sv | 218 +++++++++++++++++++++
 tb/tb_spec_peak_find.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/spec_pkg.sv
// Shared definitions for the spectral peak finder: FSM states and default sizing.
package spec_pkg;

    localparam int DEF_N_FFT  = 1024;
    localparam int DEF_BIN_HZ = 1000;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_CALC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_SCAN) || (s == ST_FLUSH) || (s == ST_CALC);
    endfunction

endpackage

// File: rtl/spec_peak_find_if.sv
// Magnitude stream carrying one FFT bin per valid beat.
interface spec_peak_find_if #(
    parameter int DATA_W = 16
) ();

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, output s_data, output s_last);
    modport slave  (input  s_valid, input  s_data, input  s_last);

endinterface

// File: rtl/peak_rank2.sv
// Keeps the two largest peak candidates; bins arrive in ascending order so a
// strict compare leaves the lower bin in place on equal magnitudes.
module peak_rank2 #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cand_vld,
    input  logic [IDX_W-1:0]  cand_bin,
    input  logic [DATA_W-1:0] cand_mag,
    output logic [IDX_W-1:0]  pk1_bin,
    output logic [DATA_W-1:0] pk1_mag,
    output logic [IDX_W-1:0]  pk2_bin,
    output logic [DATA_W-1:0] pk2_mag
);

    logic [IDX_W-1:0]  pk1_bin_q, pk1_bin_d, pk2_bin_q, pk2_bin_d;
    logic [DATA_W-1:0] pk1_mag_q, pk1_mag_d, pk2_mag_q, pk2_mag_d;

    // Insertion of a new candidate into the ordered top-2 list.
    always_comb begin
        pk1_bin_d = pk1_bin_q;
        pk1_mag_d = pk1_mag_q;
        pk2_bin_d = pk2_bin_q;
        pk2_mag_d = pk2_mag_q;
        if (clr) begin
            pk1_bin_d = '0;
            pk1_mag_d = '0;
            pk2_bin_d = '0;
            pk2_mag_d = '0;
        end else if (cand_vld) begin
            if (cand_mag > pk1_mag_q) begin
                pk2_bin_d = pk1_bin_q;
                pk2_mag_d = pk1_mag_q;
                pk1_bin_d = cand_bin;
                pk1_mag_d = cand_mag;
            end else if (cand_mag > pk2_mag_q) begin
                pk2_bin_d = cand_bin;
                pk2_mag_d = cand_mag;
            end else begin
                pk2_bin_d = pk2_bin_q;
            end
        end else begin
            pk1_bin_d = pk1_bin_q;
        end
    end

    // Ranking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk1_bin_q <= '0;
            pk1_mag_q <= '0;
            pk2_bin_q <= '0;
            pk2_mag_q <= '0;
        end else begin
            pk1_bin_q <= pk1_bin_d;
            pk1_mag_q <= pk1_mag_d;
            pk2_bin_q <= pk2_bin_d;
            pk2_mag_q <= pk2_mag_d;
        end
    end

    assign pk1_bin = pk1_bin_q;
    assign pk1_mag = pk1_mag_q;
    assign pk2_bin = pk2_bin_q;
    assign pk2_mag = pk2_mag_q;

endmodule

// File: rtl/spec_peak_find.sv
// Scans one magnitude frame for local maxima above a threshold and reports the
// two strongest peaks as bin, magnitude and frequency.
module spec_peak_find
    import spec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_FFT  = DEF_N_FFT,
    localparam int IDX_W = $clog2(N_FFT),
    parameter int LO_BIN = 1,
    parameter int HI_BIN = N_FFT / 2 - 1,
    parameter int BIN_HZ = DEF_BIN_HZ,
    parameter int FREQ_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] thresh,
    spec_peak_find_if.slave   s_if,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    output logic              frame_err,
    output logic [CNT_W-1:0]  pk_cnt,
    output logic [IDX_W-1:0]  pk1_bin,
    output logic [IDX_W-1:0]  pk2_bin,
    output logic [DATA_W-1:0] pk1_mag,
    output logic [DATA_W-1:0] pk2_mag,
    output logic [FREQ_W-1:0] pk1_freq,
    output logic [FREQ_W-1:0] pk2_freq
);

    localparam logic [IDX_W-1:0] LO_IDX   = IDX_W'(LO_BIN);
    localparam logic [IDX_W-1:0] HI_IDX   = IDX_W'(HI_BIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FFT - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [FREQ_W-1:0] HZ_F    = FREQ_W'(BIN_HZ);

    state_t state_q, state_d;

    logic [IDX_W-1:0]  cnt_q, cnt_d, pend_bin_q, pend_bin_d;
    logic [DATA_W-1:0] pend_mag_q, pend_mag_d, prev_mag_q, prev_mag_d;
    logic              pend_vld_q, pend_vld_d;
    logic              frame_err_q, frame_err_d, res_valid_q, res_valid_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic [CNT_W-1:0]  pk_cnt_q, pk_cnt_d;
    logic [FREQ_W-1:0] pk1_freq_q, pk1_freq_d, pk2_freq_q, pk2_freq_d;

    logic              frame_end_s, cur_in_rng_s, pend_eval_s, cand_vld_s, rank_clr_s;
    logic [DATA_W-1:0] cur_eff_s;
    logic [IDX_W-1:0]  rk1_bin_s, rk2_bin_s;
    logic [DATA_W-1:0] rk1_mag_s, rk2_mag_s;

    // Bins outside the search window act as zero-valued neighbours.
    assign frame_end_s  = s_if.s_last || (cnt_q == LAST_IDX);
    assign cur_in_rng_s = (cnt_q >= LO_IDX) && (cnt_q <= HI_IDX);
    assign cur_eff_s    = cur_in_rng_s ? s_if.s_data : '0;
    assign pend_eval_s  = pend_vld_q && (pend_bin_q >= LO_IDX) && (pend_bin_q <= HI_IDX)
                          && (pend_mag_q >= thresh) && (pend_mag_q > prev_mag_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear outranks start, start restarts from any state.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_SCAN;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_SCAN:  state_d = (s_if.s_valid && frame_end_s) ? ST_FLUSH : ST_SCAN;
                ST_FLUSH: state_d = ST_CALC;
                ST_CALC:  state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values per state.
    always_comb begin
        cnt_d       = cnt_q;
        pend_bin_d  = pend_bin_q;
        pend_mag_d  = pend_mag_q;
        prev_mag_d  = prev_mag_q;
        pend_vld_d  = pend_vld_q;
        frame_err_d = frame_err_q;
        res_valid_d = res_valid_q;
        pk_cnt_d    = pk_cnt_q;
        pk1_freq_d  = pk1_freq_q;
        pk2_freq_d  = pk2_freq_q;
        done_d      = 1'b0;
        busy_d      = is_busy(state_d);
        cand_vld_s  = 1'b0;
        rank_clr_s  = 1'b0;
        if (clear) begin
            res_valid_d = 1'b0;
        end else if (start) begin
            cnt_d       = '0;
            pend_bin_d  = '0;
            pend_mag_d  = '0;
            prev_mag_d  = '0;
            pend_vld_d  = 1'b0;
            frame_err_d = 1'b0;
            res_valid_d = 1'b0;
            pk_cnt_d    = '0;
            pk1_freq_d  = '0;
            pk2_freq_d  = '0;
            rank_clr_s  = 1'b1;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (s_if.s_valid) begin
                        // The new beat is the right neighbour of the pending bin.
                        cand_vld_s = pend_eval_s && (pend_mag_q >= cur_eff_s);
                        cnt_d      = cnt_q + ONE_IDX;
                        prev_mag_d = pend_mag_q;
                        pend_mag_d = cur_eff_s;
                        pend_bin_d = cnt_q;
                        pend_vld_d = 1'b1;
                        if (frame_end_s) begin
                            frame_err_d = s_if.s_last != (cnt_q == LAST_IDX);
                        end else begin
                            frame_err_d = frame_err_q;
                        end
                    end else begin
                        cand_vld_s = 1'b0;
                    end
                end
                ST_FLUSH: cand_vld_s = pend_eval_s;
                ST_CALC: begin
                    pk1_freq_d  = FREQ_W'(rk1_bin_s) * HZ_F;
                    pk2_freq_d  = FREQ_W'(rk2_bin_s) * HZ_F;
                    res_valid_d = 1'b1;
                    done_d      = 1'b1;
                end
                default: cand_vld_s = 1'b0;
            endcase
        end
        if (cand_vld_s && (pk_cnt_q != CNT_MAX)) begin
            pk_cnt_d = pk_cnt_q + CNT_ONE;
        end else begin
            pk_cnt_d = pk_cnt_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            pend_bin_q  <= '0;
            pend_mag_q  <= '0;
            prev_mag_q  <= '0;
            pend_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            res_valid_q <= 1'b0;
            pk_cnt_q    <= '0;
            pk1_freq_q  <= '0;
            pk2_freq_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_bin_q  <= pend_bin_d;
            pend_mag_q  <= pend_mag_d;
            prev_mag_q  <= prev_mag_d;
            pend_vld_q  <= pend_vld_d;
            frame_err_q <= frame_err_d;
            res_valid_q <= res_valid_d;
            pk_cnt_q    <= pk_cnt_d;
            pk1_freq_q  <= pk1_freq_d;
            pk2_freq_q  <= pk2_freq_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    peak_rank2 #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_rank (
        .clk      (clk),
        .rst      (rst),
        .clr      (rank_clr_s),
        .cand_vld (cand_vld_s),
        .cand_bin (pend_bin_q),
        .cand_mag (pend_mag_q),
        .pk1_bin  (rk1_bin_s),
        .pk1_mag  (rk1_mag_s),
        .pk2_bin  (rk2_bin_s),
        .pk2_mag  (rk2_mag_s)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign frame_err = frame_err_q;
    assign pk_cnt    = pk_cnt_q;
    assign pk1_bin   = rk1_bin_s;
    assign pk2_bin   = rk2_bin_s;
    assign pk1_mag   = rk1_mag_s;
    assign pk2_mag   = rk2_mag_s;
    assign pk1_freq  = pk1_freq_q;
    assign pk2_freq  = pk2_freq_q;

endmodule

// File: tb/tb_spec_peak_find.sv
// Directed bench for spec_peak_find with hand-computed expectations.
module tb_spec_peak_find;

    logic        clk = 1'b0;
    logic        rst, start, clear;
    logic [15:0] thresh;
    logic        busy, done, res_valid, frame_err;
    logic [7:0]  pk_cnt;
    logic [9:0]  pk1_bin, pk2_bin;
    logic [15:0] pk1_mag, pk2_mag;
    logic [31:0] pk1_freq, pk2_freq;

    logic [15:0] mag [0:1023];
    int checks = 0;
    int errors = 0;

    spec_peak_find_if #(.DATA_W(16)) s_if ();

    spec_peak_find dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .thresh    (thresh),
        .s_if      (s_if),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .frame_err (frame_err),
        .pk_cnt    (pk_cnt),
        .pk1_bin   (pk1_bin),
        .pk2_bin   (pk2_bin),
        .pk1_mag   (pk1_mag),
        .pk2_mag   (pk2_mag),
        .pk1_freq  (pk1_freq),
        .pk2_freq  (pk2_freq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 1024; i++) mag[i] = v;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beats(input int n, input bit with_last);
        for (int k = 0; k < n; k++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = mag[k];
            s_if.s_last  = with_last && (k == n - 1);
            @(negedge clk);
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        s_if.s_data  = 16'd0;
    endtask

    // Called on the first falling edge after the final beat was accepted.
    task automatic expect_done(input string tag);
        int c;
        c = 1;
        while (!done && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_lat"}, 64'(c), 64'd3);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic check_pk(input string tag,
                            input logic [63:0] b1, input logic [63:0] m1, input logic [63:0] f1,
                            input logic [63:0] b2, input logic [63:0] m2, input logic [63:0] f2,
                            input logic [63:0] cnt, input logic [63:0] ferr);
        chk({tag, "_pk1_bin"},  64'(pk1_bin),  b1);
        chk({tag, "_pk1_mag"},  64'(pk1_mag),  m1);
        chk({tag, "_pk1_freq"}, 64'(pk1_freq), f1);
        chk({tag, "_pk2_bin"},  64'(pk2_bin),  b2);
        chk({tag, "_pk2_mag"},  64'(pk2_mag),  m2);
        chk({tag, "_pk2_freq"}, 64'(pk2_freq), f2);
        chk({tag, "_pk_cnt"},   64'(pk_cnt),   cnt);
        chk({tag, "_frame_err"}, 64'(frame_err), ferr);
    endtask

    initial begin
        bit seen_done;
        rst = 1'b1; start = 1'b0; clear = 1'b0; thresh = 16'd50;
        s_if.s_valid = 1'b0; s_if.s_data = 16'd0; s_if.s_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        check_pk("rst", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single tone.
        fill(16'd10); mag[100] = 16'd5000;
        start_pulse();
        chk("t1_busy", 64'(busy), 64'd1);
        beats(1024, 1'b1);
        chk("t1_busy_flush", 64'(busy), 64'd1);
        expect_done("t1");
        check_pk("t1", 64'd100, 64'd5000, 64'd100000, 64'd0, 64'd0, 64'd0, 64'd1, 64'd0);

        // Two tones, stronger one later in the frame.
        fill(16'd10); mag[50] = 16'd3000; mag[150] = 16'd4000;
        start_pulse();
        beats(1024, 1'b1);
        expect_done("t2");
        check_pk("t2", 64'd150, 64'd4000, 64'd150000, 64'd50, 64'd3000, 64'd50000, 64'd2, 64'd0);

        // Plateau at 20/21 and equal peaks at 30/40.
        fill(16'd10); mag[20] = 16'd800; mag[21] = 16'd800; mag[30] = 16'd900; mag[40] = 16'd900;
        start_pulse();
        beats(1024, 1'b1);
        expect_done("t3");
        check_pk("t3", 64'd30, 64'd900, 64'd30000, 64'd40, 64'd900, 64'd40000, 64'd3, 64'd0);

        // DC excluded; top bin of a 512-beat frame found in the flush cycle.
        fill(16'd10); mag[0] = 16'd60000; mag[511] = 16'd700;
        start_pulse();
        beats(512, 1'b1);
        expect_done("t4");
        check_pk("t4", 64'd511, 64'd700, 64'd511000, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1);

        // Early s_last at beat 600.
        fill(16'd10); mag[100] = 16'd5000;
        start_pulse();
        beats(601, 1'b1);
        expect_done("t5");
        check_pk("t5", 64'd100, 64'd5000, 64'd100000, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1);

        // Every odd bin a peak: 256 peaks saturate the 8-bit count.
        fill(16'd10);
        for (int k = 1; k < 512; k += 2) mag[k] = 16'd100;
        start_pulse();
        beats(1024, 1'b1);
        expect_done("t6");
        check_pk("t6", 64'd1, 64'd100, 64'd1000, 64'd3, 64'd100, 64'd3000, 64'd255, 64'd0);

        // Clear at beat 300: no done, results kept but invalid, later beats ignored.
        fill(16'd10); mag[100] = 16'd5000;
        start_pulse();
        beats(300, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_res_valid", 64'(res_valid), 64'd0);
        mag[5] = 16'd9000;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = mag[k];
            @(negedge clk);
            seen_done = seen_done | done;
        end
        s_if.s_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        chk("t7_no_done", 64'(seen_done), 64'd0);
        chk("t7_pk1_bin", 64'(pk1_bin), 64'd100);
        chk("t7_pk_cnt", 64'(pk_cnt), 64'd1);
        chk("t7_res_valid_hold", 64'(res_valid), 64'd0);

        // Reset in the middle of a scan.
        fill(16'd10); mag[100] = 16'd5000;
        start_pulse();
        beats(200, 1'b0);
        chk("t8_pre_cnt", 64'(pk_cnt), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t8_busy", 64'(busy), 64'd0);
        check_pk("t8", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        rst = 1'b0;
        beats(200, 1'b0);
        chk("t8_ignored_busy", 64'(busy), 64'd0);
        chk("t8_ignored_cnt", 64'(pk_cnt), 64'd0);

        // Start and clear together: clear wins.
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        chk("t9_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t9_busy2", 64'(busy), 64'd0);
        chk("t9_done", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
